// File: rtl/fetch_pc_gen.sv
// fetch_pc_gen - dual-slot fetch next-PC generator.
//
// F1 holds pc_q. It is presented to the BTB (currentPC/currentPC2) and to
// instruction memory (imem_addr). The BTB answers one cycle later, so the
// answer lines up with the pair that has just moved into F2. F2 resolves
// the prediction for that pair and shows it to decode. A predicted-taken
// pair reloads pc_q from its target and costs one bubble. A branch-pipe
// redirect overrides everything else.
//
// Ports
//   clk, reset              clock; synchronous active-high reset
//   stall_in                decode cannot take the current pair
//   redirect_en/_pc         mispredict redirect from the branch pipe
//   btb_taken/_predictedPC  BTB answer for slot0 (PC looked up last cycle)
//   btb_taken2/_predictedPC2  BTB answer for slot1
//   currentPC/currentPC2    BTB lookup PCs (pc_q, pc_q+4)
//   imem_addr               instruction fetch address (pc_q)
//   out_valid0/1, out_pc    F2 pair to decode
//   out_pred_taken/_slot/_target  resolved prediction for the F2 pair
module fetch_pc_gen #(
    parameter logic [0:31] RESET_PC = 32'h0000_0000,
    parameter logic [0:31] PC_STEP  = 32'd8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall_in,
    input  logic        redirect_en,
    input  logic [0:31] redirect_pc,
    input  logic        btb_taken,
    input  logic [0:31] btb_predictedPC,
    input  logic        btb_taken2,
    input  logic [0:31] btb_predictedPC2,
    output logic [0:31] currentPC,
    output logic [0:31] currentPC2,
    output logic [0:31] imem_addr,
    output logic        out_valid0,
    output logic        out_valid1,
    output logic [0:31] out_pc,
    output logic        out_pred_taken,
    output logic        out_pred_slot,
    output logic [0:31] out_pred_target
);

    typedef enum logic [1:0] {RUN, HOLD, BUBBLE} state_e;

    typedef struct packed {
        logic        t0;
        logic [0:31] tgt0;
        logic        t1;
        logic [0:31] tgt1;
    } pred_t;

    state_e      state_q, state_d;
    logic [0:31] pc_q, pc_d;
    logic [0:31] f2_pc_q, f2_pc_d;
    logic        f2_valid_q, f2_valid_d;
    logic        fresh_q, fresh_d;
    pred_t       pred_q, pred_d;

    pred_t       pred_eff;
    logic        pair_valid;
    logic        take;
    logic        take_slot;
    logic [0:31] take_tgt;

    function automatic logic [0:31] align(input logic [0:31] a);
        align = {a[0:29], 2'b00};
    endfunction

    // Resolve the F2 pair. The live BTB answer belongs to this pair only in
    // the first cycle it sits in F2. After that, the BTB is looking at
    // pc_q, so the copy latched in that first cycle is used instead.
    always_comb begin
        pred_eff   = fresh_q ? {btb_taken, btb_predictedPC, btb_taken2, btb_predictedPC2}
                             : pred_q;
        pair_valid = f2_valid_q && (state_q != BUBBLE);
        take       = 1'b0;
        take_slot  = 1'b0;
        take_tgt   = '0;
        if (pair_valid) begin
            if (pred_eff.t0) begin
                take     = 1'b1;
                take_tgt = pred_eff.tgt0;
            end else if (pred_eff.t1) begin
                take      = 1'b1;
                take_slot = 1'b1;
                take_tgt  = pred_eff.tgt1;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        f2_pc_d    = f2_pc_q;
        f2_valid_d = f2_valid_q;
        fresh_d    = 1'b0;
        pred_d     = fresh_q ? pred_eff : pred_q;

        if (redirect_en) begin
            pc_d       = align(redirect_pc);
            f2_valid_d = 1'b0;
            state_d    = BUBBLE;
        end else if (stall_in && pair_valid) begin
            // Hold everything. pc_q keeps being looked up, and the latched
            // prediction stands in for the stale BTB answer.
            state_d = HOLD;
        end else if (take) begin
            // The pair fetched this cycle (pc_q) is on the wrong path, so it
            // is dropped.
            pc_d       = align(take_tgt);
            f2_valid_d = 1'b0;
            state_d    = BUBBLE;
        end else begin
            f2_pc_d    = pc_q;
            f2_valid_d = 1'b1;
            fresh_d    = 1'b1;
            pc_d       = align(pc_q + PC_STEP);
            state_d    = RUN;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= RUN;
            pc_q       <= align(RESET_PC);
            f2_pc_q    <= '0;
            f2_valid_q <= 1'b0;
            fresh_q    <= 1'b0;
            pred_q     <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            f2_pc_q    <= f2_pc_d;
            f2_valid_q <= f2_valid_d;
            fresh_q    <= fresh_d;
            pred_q     <= pred_d;
        end
    end

    assign currentPC       = pc_q;
    assign currentPC2      = pc_q + 32'd4;
    assign imem_addr       = pc_q;
    assign out_valid0      = pair_valid;
    assign out_valid1      = pair_valid && !(take && !take_slot);
    assign out_pc          = f2_pc_q;
    assign out_pred_taken  = take;
    assign out_pred_slot   = take_slot;
    assign out_pred_target = take_tgt;

endmodule
